iob_mem_arbiter: RTL
====================

// Module: iob_mem_arbiter
// PURPOSE
//  Round-robin arbiter sharing one IOb native memory port (cache front-end + vec_ram) among
//  N_REQ IOb native masters. Grants one request at a time, holds the grant until accepted.
//  Tracks outstanding reads in an ID FIFO so each in-order rvalid/rdata returns to its issuer.
// PARAMETERS
//  N_REQ     2   number of requesting masters (>=2)
//  ADDR_W    32  byte address width (`IOB_ADDR_W)
//  DATA_W    32  data width (`IOB_WDATA_W); wstrb width DATA_W/8
//  OUTST     4   max outstanding reads (ID FIFO depth, power of 2)
// PORTS
//  clk_i         in   1               clock, all logic rising-edge
//  arst_n_i      in   1               asynchronous reset, active-low
//  req_valid_i   in   N_REQ           per-master request valid
//  req_addr_i    in   N_REQ*ADDR_W    packed addresses, master k at [k*ADDR_W +: ADDR_W]
//  req_wdata_i   in   N_REQ*DATA_W    packed write data
//  req_wstrb_i   in   N_REQ*DATA_W/8  packed strobes; all-zero = read
//  req_ready_o   out  N_REQ           request accepted this cycle
//  req_rvalid_o  out  N_REQ           read data valid to master k
//  req_rdata_o   out  N_REQ*DATA_W    read data (broadcast, qualified by req_rvalid_o)
//  mem_valid_o / mem_addr_o / mem_wdata_o / mem_wstrb_o   out  1/ADDR_W/DATA_W/DATA_W/8
//  mem_ready_i / mem_rvalid_i / mem_rdata_i               in   1/1/DATA_W
//  err_o         out  1               sticky: rvalid received with ID FIFO empty
// BEHAVIOUR
//  Reset: all outputs 0; RR pointer = 0; FIFO empty; state IDLE; err_o = 0.
//  FSM IDLE: select first valid master at/after RR pointer (combinational, same cycle);
//   drive mem_* from it; if mem_ready_i -> accept, else go LOCK with grant id registered.
//  FSM LOCK: keep same master on mem_*, no re-arbitration; on mem_ready_i accept -> IDLE.
//  Accept = mem_valid_o & mem_ready_i: req_ready_o[grant]=1 that cycle only; RR pointer <=
//   grant+1 (wraps N_REQ-1 -> 0). Zero-cycle accept allowed (mem_ready_i tied 1 in system).
//  Read accept (wstrb==0): push grant id to FIFO. Writes never push, never get rvalid.
//  Read gating: if FIFO full, a read master is not eligible (mem_valid_o stays 0 for it);
//   writes still proceed. A held LOCK read never exists while full (checked at grant).
//  Return: mem_rvalid_i pops FIFO head; req_rvalid_o[head]=1 same cycle (combinational),
//   req_rdata_o = mem_rdata_i. Returns are in issue order; minimum 1-cycle read latency.
//  Push and pop in same cycle: both occur, count unchanged; legal even when full.
//  mem_rvalid_i with FIFO empty: no req_rvalid_o, err_o <= 1 until reset.
//  Requester dropping valid in LOCK is a protocol violation; arbiter keeps grant.
//  arst_n_i low mid-transaction: everything cleared asynchronously; in-flight reads lost.
// CONFIGURATION
//  MEM_ARB_PERF_EN defined: adds output grant_cnt_o [N_REQ*32], per-master accept counters,
//   +1 per accept, saturate at 32'hFFFF_FFFF, reset 0.
//  Undefined: port and counters absent; no other behaviour change.
// STRUCTURE
//  Shared package/header mem_arb.vh: ID width localparam ($clog2(N_REQ)), FSM encodings
//   ST_IDLE=1'b0 / ST_LOCK=1'b1, default widths from memory.vh.
//  Sub-module iob_mem_arb_id_fifo: synchronous FIFO, width ID_W, depth OUTST, push/pop/
//   full/empty/head, simultaneous push+pop, async active-low reset.
// TESTING
//  1 Single master 0 read addr 0x10, mem_ready=1, rvalid 1 cycle later rdata 0xA5A5A5A5
//    -> req_ready_o=01 cycle 0, req_rvalid_o=01 cycle 1 with 0xA5A5A5A5.
//  2 Both masters valid every cycle, writes -> grants alternate 0,1,0,1; grant_cnt both 2
//    after 4 accepts (PERF_EN).
//  3 mem_ready_i low 3 cycles while master 0 granted, master 1 raises valid -> mem_*
//    stays on master 0 until ready; master 1 accepted next cycle.
//  4 OUTST=4, master 1 issues 5 reads, no rvalid -> 5th not accepted until one rvalid
//    pops; write from master 0 accepted meanwhile.
//  5 Interleaved reads m0,m1,m0 with rvalid latency 2 -> rvalid order 01,10,01.
//  6 mem_rvalid_i with empty FIFO -> err_o=1 sticky; arst_n_i low mid-LOCK -> all 0.

Source files
------------

// File: rtl/iob_mem_arbiter_pkg.sv
// Shared definitions for the IOb memory arbiter: default bus widths, FSM encoding and
// the grant-id width helper.
// No ports; imported by iob_mem_arbiter and iob_mem_arbiter_id_fifo.
package iob_mem_arbiter_pkg;

  // Default IOb native widths.
  localparam int IOB_ADDR_W = 32;
  localparam int IOB_DATA_W = 32;

  // Default arbiter sizing.
  localparam int ARB_N_REQ = 2;
  localparam int ARB_OUTST = 4;

  // IDLE arbitrates combinationally; LOCK holds the registered grant until accepted.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  // Width of a requester id.
  // A single requester would give $clog2 = 0, so the width is clamped to at least one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_mem_arbiter_id_fifo.sv
// Purpose: in-order FIFO of requester ids for reads that are outstanding on the memory port.
// Latency: the head is visible combinationally; a push becomes visible on the next cycle.
// Backpressure: full_o blocks a push unless a pop happens in the same cycle.
//   A pop while empty is ignored.
// Ports: clk_i/arst_n_i, push_i+din_i, pop_i, dout_o (head), full_o, empty_o.
module iob_mem_arbiter_id_fifo
  import iob_mem_arbiter_pkg::*;
#(
  parameter int W     = 1,
  parameter int DEPTH = ARB_OUTST
) (
  input  logic         clk_i,
  input  logic         arst_n_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_q];

  // A pop frees the head slot in the same cycle, so a push is still legal while full.
  // In that case the write slot equals the slot being read out.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    if (push_ok) begin
      mem_d[wr_q] = din_i;
      wr_d        = (wr_q == AW'(DEPTH-1)) ? '0 : wr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_d = (rd_q == AW'(DEPTH-1)) ? '0 : rd_q + AW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/iob_mem_arbiter.sv
// Purpose: round-robin arbiter sharing one IOb native memory port among N_REQ masters.
//   Returns each in-order read response to the master that issued it.
// Latency: grant, request and accept all happen in the same cycle (no added latency).
//   A read response is routed in the cycle it arrives.
// Backpressure: mem_ready_i low holds the granted master on the port.
//   A full id FIFO blocks reads only; writes still pass.
// Ports:
//   req_*  : packed per-master IOb request and response signals.
//   mem_*  : the shared memory port.
//   err_o  : sticky flag, set when a response arrives with no outstanding read.
// Optional: define MEM_ARB_PERF_EN to add grant_cnt_o, a saturating 32-bit accept counter
//   per master.
module iob_mem_arbiter
  import iob_mem_arbiter_pkg::*;
#(
  parameter int N_REQ  = ARB_N_REQ,
  parameter int ADDR_W = IOB_ADDR_W,
  parameter int DATA_W = IOB_DATA_W,
  parameter int OUTST  = ARB_OUTST
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata_i,
  input  logic [N_REQ*DATA_W/8-1:0] req_wstrb_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [N_REQ-1:0]          req_rvalid_o,
  output logic [N_REQ*DATA_W-1:0]   req_rdata_o,
  output logic                      mem_valid_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  output logic [DATA_W/8-1:0]       mem_wstrb_o,
  input  logic                      mem_ready_i,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_W-1:0]         mem_rdata_i,
  output logic                      err_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [N_REQ*32-1:0]       grant_cnt_o
`endif
);

  localparam int ID_W   = id_width(N_REQ);
  localparam int STRB_W = DATA_W / 8;

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [ID_W-1:0] rr_q, rr_d;
  logic            err_q, err_d;

  logic [N_REQ-1:0] is_rd, elig;
  logic             lo_vld, hi_vld;
  logic [ID_W-1:0]  lo_id, hi_id, pick_id;
  logic             gnt_vld, gnt_rd, accept;
  logic [ID_W-1:0]  gnt_id;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ID_W-1:0]  fifo_head;

  // A read is not eligible while the id FIFO is full: it could not be tracked.
  always_comb begin
    is_rd = '0;
    elig  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      is_rd[k] = (req_wstrb_i[k*STRB_W +: STRB_W] == '0);
      elig[k]  = req_valid_i[k] & (~is_rd[k] | ~fifo_full);
    end
  end

  // Round-robin pick. lo_* is the lowest eligible index overall.
  // hi_* is the lowest eligible index at or after the pointer, and wins when it exists.
  always_comb begin
    lo_vld = 1'b0;
    lo_id  = '0;
    hi_vld = 1'b0;
    hi_id  = '0;
    for (int j = N_REQ-1; j >= 0; j--) begin
      if (elig[j]) begin
        lo_vld = 1'b1;
        lo_id  = ID_W'(j);
      end
      if (elig[j] && (j >= int'(rr_q))) begin
        hi_vld = 1'b1;
        hi_id  = ID_W'(j);
      end
    end
    pick_id = hi_vld ? hi_id : lo_id;
  end

  // In LOCK the registered grant owns the port regardless of its valid.
  // A requester dropping valid there is a protocol violation.
  always_comb begin
    gnt_vld = (state_q == ST_LOCK) | lo_vld;
    gnt_id  = (state_q == ST_LOCK) ? grant_q : pick_id;
    gnt_rd  = is_rd[gnt_id];
    accept  = gnt_vld & mem_ready_i;
  end

  always_comb begin
    mem_valid_o = gnt_vld;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    if (gnt_vld) begin
      mem_addr_o  = req_addr_i[int'(gnt_id)*ADDR_W +: ADDR_W];
      mem_wdata_o = req_wdata_i[int'(gnt_id)*DATA_W +: DATA_W];
      mem_wstrb_o = req_wstrb_i[int'(gnt_id)*STRB_W +: STRB_W];
    end
  end

  assign fifo_push = accept & gnt_rd;
  assign fifo_pop  = mem_rvalid_i & ~fifo_empty;

  always_comb begin
    req_ready_o  = '0;
    req_rvalid_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      req_ready_o[k]  = accept & (gnt_id == ID_W'(k));
      req_rvalid_o[k] = fifo_pop & (fifo_head == ID_W'(k));
    end
  end

  // Read data is broadcast; only the master with rvalid picks it up.
  assign req_rdata_o = {N_REQ{mem_rdata_i}};
  assign err_o       = err_q;

  iob_mem_arbiter_id_fifo #(
    .W     (ID_W),
    .DEPTH (OUTST)
  ) u_id_fifo (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .push_i   (fifo_push),
    .din_i    (gnt_id),
    .pop_i    (fifo_pop),
    .dout_o   (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    err_d   = err_q | (mem_rvalid_i & fifo_empty);
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld && !mem_ready_i) begin
          state_d = ST_LOCK;
          grant_d = gnt_id;
        end
      end
      ST_LOCK: begin
        if (mem_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // After an accept, the master following the winner gets first look next time.
    if (accept) begin
      rr_d = (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] cnt_q [N_REQ];
  logic [31:0] cnt_d [N_REQ];

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      cnt_d[k] = cnt_q[k];
      if (req_ready_o[k] && (cnt_q[k] != 32'hFFFF_FFFF)) cnt_d[k] = cnt_q[k] + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int k = 0; k < N_REQ; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int k = 0; k < N_REQ; k++) grant_cnt_o[k*32 +: 32] = cnt_q[k];
  end
`endif

endmodule
